// File: rtl/pushbuttons_leds_debounce.sv
// pushbuttons_leds_debounce: N_CH active-low raw pushbuttons, each synchronised,
// debounced and driving one registered LED in a run-time selected mode
// (direct, toggle, blink-while-held, inverted), plus a one-cycle press strobe.
module pushbuttons_leds_debounce #(
  parameter int N_CH            = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] PB_n,
  input  logic [1:0]      MODE,
  output logic [N_CH-1:0] LED,
  output logic [N_CH-1:0] PRESS
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_INVERT = 2'b11
  } led_mode_e;

  led_mode_e mode;
  assign mode = led_mode_e'(MODE);

  // Synchroniser stages (reset to released = 1)
  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [N_CH-1:0] sync;

  // Debounce state
  logic [DB_W-1:0] dbcnt_q [N_CH];
  logic [DB_W-1:0] dbcnt_d [N_CH];
  logic [N_CH-1:0] db_q, db_d;
  logic [N_CH-1:0] db_dly_q;

  // Toggle, blink and LED state
  logic [N_CH-1:0] tog_q, tog_d;
  logic [BL_W-1:0] blcnt_q [N_CH];
  logic [BL_W-1:0] blcnt_d [N_CH];
  logic [N_CH-1:0] phase_q, phase_d;
  logic [N_CH-1:0] led_q, led_d;
  logic [N_CH-1:0] press;

  assign sync  = ~sync2_q;
  assign press = db_q & ~db_dly_q;
  assign PRESS = press;
  assign LED   = led_q;

  // Per-channel next-state: debounce counter, toggle, blink timer and LED mux
  always_comb begin
    db_d    = db_q;
    tog_d   = tog_q;
    phase_d = phase_q;
    led_d   = led_q;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      dbcnt_d[ch] = '0;
      blcnt_d[ch] = '0;

      if (sync[ch] != db_q[ch]) begin
        if (dbcnt_q[ch] == DB_MAX) begin
          db_d[ch] = ~db_q[ch];
        end else begin
          dbcnt_d[ch] = dbcnt_q[ch] + 1'b1;
        end
      end

      tog_d[ch] = tog_q[ch] ^ press[ch];

      if (!db_q[ch]) begin
        phase_d[ch] = 1'b1;
      end else if (blcnt_q[ch] == BL_MAX) begin
        phase_d[ch] = ~phase_q[ch];
      end else begin
        blcnt_d[ch] = blcnt_q[ch] + 1'b1;
      end

      // Blink uses the registered phase: with the LED one register behind,
      // this makes the first lit half-period a full BLINK_CYCLES long.
      unique case (mode)
        MODE_DIRECT: led_d[ch] = db_q[ch];
        MODE_TOGGLE: led_d[ch] = tog_d[ch];
        MODE_BLINK:  led_d[ch] = db_q[ch] & phase_q[ch];
        MODE_INVERT: led_d[ch] = ~db_q[ch];
        default:     led_d[ch] = db_q[ch];
      endcase
    end
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      db_q     <= '0;
      db_dly_q <= '0;
      tog_q    <= '0;
      phase_q  <= '1;
      led_q    <= '0;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        dbcnt_q[ch] <= '0;
        blcnt_q[ch] <= '0;
      end
    end else begin
      sync1_q  <= PB_n;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      tog_q    <= tog_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        dbcnt_q[ch] <= dbcnt_d[ch];
        blcnt_q[ch] <= blcnt_d[ch];
      end
    end
  end

endmodule

// File: tb/tb_pushbuttons_leds_debounce.sv
// Directed bench for pushbuttons_leds_debounce (N_CH=2, DEBOUNCE=4, BLINK=3).
// Each step drives inputs, queues the expected outputs after the next edge,
// then pops and compares them once that edge has happened.
module tb_pushbuttons_leds_debounce;

  localparam logic [1:0] DIR = 2'b00;
  localparam logic [1:0] TOG = 2'b01;
  localparam logic [1:0] BLK = 2'b10;
  localparam logic [1:0] INV = 2'b11;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] PB_n;
  logic [1:0] MODE;
  logic [1:0] LED;
  logic [1:0] PRESS;

  typedef struct {
    logic [1:0] led;
    logic [1:0] press;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  pushbuttons_leds_debounce #(
    .N_CH(2),
    .DEBOUNCE_CYCLES(4),
    .BLINK_CYCLES(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .PB_n(PB_n),
    .MODE(MODE),
    .LED(LED),
    .PRESS(PRESS)
  );

  always #5 CLK = ~CLK;

  task automatic step(input logic rst, input logic [1:0] pb, input logic [1:0] mode,
                      input logic [1:0] eled, input logic [1:0] epress, input string tag);
    exp_t  e;
    string t;
    RST  = rst;
    PB_n = pb;
    MODE = mode;
    e.led   = eled;
    e.press = epress;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (LED === e.led) else begin
      bad++;
      $error("FAIL %s LED observed=%b expected=%b", t, LED, e.led);
    end
    total++;
    assert (PRESS === e.press) else begin
      bad++;
      $error("FAIL %s PRESS observed=%b expected=%b", t, PRESS, e.press);
    end
  endtask

  function automatic logic blink_on(input int k, input int last);
    return (k >= 6) && (k <= last) && (((k - 6) / 3) % 2 == 0);
  endfunction

  initial begin
    // Reset, then a clean press/release on channel 0 in DIRECT mode
    repeat (3) step(1'b1, 2'b11, DIR, 2'b00, 2'b00, "reset");
    for (int k = 0; k < 10; k++)
      step(1'b0, 2'b10, DIR, (k >= 6) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00, "press0");
    for (int k = 0; k < 10; k++)
      step(1'b0, 2'b11, DIR, (k >= 6) ? 2'b00 : 2'b01, 2'b00, "release0");

    // Glitch rejection: 3 low, 1 high, 3 low, then high
    for (int k = 0; k < 15; k++)
      step(1'b0, (k < 3 || (k >= 4 && k < 7)) ? 2'b10 : 2'b11, DIR, 2'b00, 2'b00, "glitch");

    // TOGGLE: three press/release cycles on channel 1; tog[0] is already 1
    for (int c = 0; c < 3; c++) begin
      logic o, n;
      o = (c % 2 == 1);
      n = ~o;
      for (int k = 0; k < 10; k++)
        step(1'b0, 2'b01, TOG, {(k >= 6) ? n : o, 1'b1}, (k == 5) ? 2'b10 : 2'b00, "toggle_press");
      for (int k = 0; k < 10; k++)
        step(1'b0, 2'b11, TOG, {n, 1'b1}, 2'b00, "toggle_release");
    end

    // Mode switch: INVERT shows ~db, back to TOGGLE shows preserved tog, DIRECT shows db
    repeat (2) step(1'b0, 2'b11, INV, 2'b11, 2'b00, "invert");
    repeat (2) step(1'b0, 2'b11, TOG, 2'b11, 2'b00, "toggle_back");
    step(1'b0, 2'b11, DIR, 2'b00, 2'b00, "direct_back");

    // BLINK: hold channel 0 for 20 cycles, release, then re-press for 10
    for (int k = 0; k < 30; k++)
      step(1'b0, (k < 20) ? 2'b10 : 2'b11, BLK, {1'b0, blink_on(k, 25)},
           (k == 5) ? 2'b01 : 2'b00, "blink");
    for (int k = 0; k < 20; k++)
      step(1'b0, (k < 10) ? 2'b10 : 2'b11, BLK, {1'b0, blink_on(k, 15)},
           (k == 5) ? 2'b01 : 2'b00, "blink_repress");

    // Reset mid-debounce (counter at 2) in INVERT mode, button held throughout
    for (int k = 0; k < 4; k++)
      step(1'b0, 2'b10, INV, 2'b11, 2'b00, "inv_predb");
    repeat (2) step(1'b1, 2'b10, INV, 2'b00, 2'b00, "mid_reset");
    for (int k = 0; k < 10; k++)
      step(1'b0, 2'b10, INV, (k >= 6) ? 2'b10 : 2'b11, (k == 5) ? 2'b01 : 2'b00, "post_reset");
    repeat (2) step(1'b0, 2'b10, TOG, 2'b01, 2'b00, "tog_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
